// File: rtl/pulse_sync_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// pulse_sync_pkg: shared constants and helpers for the multi-channel pulse synchronizer
// Revision: 1.0
// ------------------------------------------------------------------------
package pulse_sync_pkg;

  localparam int EDGE_TOGGLE     = 0;
  localparam int EDGE_RISE       = 1;
  localparam int SYNC_STAGES_MIN = 2;

  // ceil(log2(n)), never below 1 so a single channel still has a 1-bit index
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_bit.sv
`default_nettype none
// ------------------------------------------------------------------------
// cdc_sync_bit: one-bit multi-flop synchronizer with synchronous active-high reset
// Revision: 1.0
// ------------------------------------------------------------------------
module cdc_sync_bit
  import pulse_sync_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // A chain shorter than two flops gives no metastability protection
  localparam int DEPTH = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pulse_sync_mc_rx.sv
`default_nettype none
// ------------------------------------------------------------------------
// pulse_sync_mc_rx: per-channel toggle sync, pending counters and round-robin event port; option PSYNC_GLITCH_FILTER_EN
// Revision: 1.0
// ------------------------------------------------------------------------
module pulse_sync_mc_rx
  import pulse_sync_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3,
  parameter int EDGE_MODE   = EDGE_TOGGLE,
  parameter int CH_W        = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] tgl_in,
  output logic [NUM_CH-1:0] ack_out,
  output logic              evt_vld,
  input  logic              evt_rdy,
  output logic [CH_W-1:0]   evt_ch,
  output logic [NUM_CH-1:0] ovf,
  input  logic              ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] sync_lvl;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] prev_d;
  logic [NUM_CH-1:0] edge_det;

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] dec;
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] ovf_d;

  logic              load;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  int                idx;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   ptr_d;
  logic              evt_vld_q;
  logic              evt_vld_d;
  logic [CH_W-1:0]   evt_ch_q;
  logic [CH_W-1:0]   evt_ch_d;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
      cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
      ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (tgl_in[i]),
        .q   (sync_lvl[i])
      );
    end
  endgenerate

`ifdef PSYNC_GLITCH_FILTER_EN
  logic [NUM_CH-1:0] filt_q;
  logic [NUM_CH-1:0] filt_d;

  // A level is accepted once it has been stable for two samples; otherwise keep the last accepted level
  always_comb begin
    filt_d  = sync_lvl;
    ack_out = prev_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync_lvl[i] == filt_q[i]) ack_out[i] = sync_lvl[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end
`else
  assign ack_out = sync_lvl;
`endif

  always_comb begin
    prev_d = ack_out;
    if (EDGE_MODE == EDGE_RISE) begin
      edge_det = ack_out & ~prev_q;
    end else begin
      edge_det = ack_out ^ prev_q;
    end
  end

  // Round-robin search from ptr; descending loop so the smallest offset wins
  always_comb begin
    load      = !evt_vld_q || evt_rdy;
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_CH;
      if (cnt_q[idx] != '0) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    evt_vld_d = evt_vld_q;
    evt_ch_d  = evt_ch_q;
    if (load) begin
      evt_vld_d = grant_vld;
      if (grant_vld) begin
        evt_ch_d = grant_ch;
        ptr_d    = (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + CH_W'(1);
      end
    end
  end

  always_comb begin
    ovf_d = ovf_clr ? '0 : ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      dec[i]   = load && grant_vld && (int'(grant_ch) == i);
      if (edge_det[i] && !dec[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (!edge_det[i] && dec[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '0;
      ovf_q     <= '0;
      ptr_q     <= '0;
      evt_vld_q <= 1'b0;
      evt_ch_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      prev_q    <= prev_d;
      ovf_q     <= ovf_d;
      ptr_q     <= ptr_d;
      evt_vld_q <= evt_vld_d;
      evt_ch_q  <= evt_ch_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign evt_vld = evt_vld_q;
  assign evt_ch  = evt_ch_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sync_mc_rx.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_pulse_sync_mc_rx: directed self-checking bench for toggle and rising-edge builds
// Revision: 1.0
// ------------------------------------------------------------------------
module tb_pulse_sync_mc_rx;

`ifdef PSYNC_GLITCH_FILTER_EN
  localparam int FLT = 1;
`else
  localparam int FLT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tgl_in = '0;
  logic [3:0] tgl_r = '0;
  logic       evt_rdy = 1'b1;
  logic       ovf_clr = 1'b0;
  logic [3:0] ack_out, ack_r, ovf, ovf_r;
  logic       evt_vld, vld_r;
  logic [1:0] evt_ch, ch_r;

  int n_tests = 0;
  int n_fail  = 0;
  int q_ch[$];
  int n_rise  = 0;

  always #5 clk = ~clk;

  pulse_sync_mc_rx #(.NUM_CH(4), .SYNC_STAGES(2), .CNT_W(3), .EDGE_MODE(0)) dut (
    .clk(clk), .rst(rst), .tgl_in(tgl_in), .ack_out(ack_out), .evt_vld(evt_vld),
    .evt_rdy(evt_rdy), .evt_ch(evt_ch), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  pulse_sync_mc_rx #(.NUM_CH(4), .SYNC_STAGES(2), .CNT_W(3), .EDGE_MODE(1)) dut_r (
    .clk(clk), .rst(rst), .tgl_in(tgl_r), .ack_out(ack_r), .evt_vld(vld_r),
    .evt_rdy(evt_rdy), .evt_ch(ch_r), .ovf(ovf_r), .ovf_clr(ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int qv(input int i);
    return (i < q_ch.size()) ? q_ch[i] : -1;
  endfunction

  // Handshake seen at negedge completes on the following posedge
  always @(negedge clk) begin
    if (!rst) begin
      if (evt_vld && evt_rdy) q_ch.push_back(int'(evt_ch));
      if (vld_r && evt_rdy) n_rise++;
    end
  end

  task automatic do_reset();
    tgl_in = '0;
    tgl_r  = '0;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    q_ch.delete();
    n_rise = 0;
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    check("rst_vld", evt_vld, 0);
    check("rst_ch",  evt_ch, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ack", ack_out, 0);

    // single event and its latency
    do_reset();
    evt_rdy = 1'b1;
    tgl_in[2] = 1'b1;
    tick();
    check("t1_ack_e1", ack_out, 4'b0000);
    tick();
    check("t1_ack_e2", ack_out, (FLT == 1) ? 4'b0000 : 4'b0100);
    tick(1 + FLT);
    check("t1_vld_e3", evt_vld, 0);
    tick();
    check("t1_vld_e4", evt_vld, 1);
    check("t1_ch_e4",  evt_ch, 2);
    tick();
    check("t1_vld_e5", evt_vld, 0);
    check("t1_ack",    ack_out, 4'b0100);
    check("t1_ovf",    ovf, 0);
    check("t1_cnt",    q_ch.size(), 1);

    // round-robin ordering
    do_reset();
    tgl_in = 4'b1011;
    tick(8);
    check("rr_n1", q_ch.size(), 3);
    check("rr_0",  qv(0), 0);
    check("rr_1",  qv(1), 1);
    check("rr_2",  qv(2), 3);
    tgl_in[2] = ~tgl_in[2];
    tick(8);
    tgl_in = tgl_in ^ 4'b1001;
    tick(8);
    check("rr_n2", q_ch.size(), 6);
    check("rr_3",  qv(3), 2);
    check("rr_4",  qv(4), 3);
    check("rr_5",  qv(5), 0);

    // backpressure hold
    do_reset();
    evt_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tgl_in[1] = ~tgl_in[1];
      tick(2);
    end
    tick(4);
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {evt_vld, evt_ch}, 3'b101);
      tick();
    end
    evt_rdy = 1'b1;
    tick(10);
    check("bp_n",   q_ch.size(), 3);
    check("bp_q0",  qv(0), 1);
    check("bp_q2",  qv(2), 1);
    check("bp_vld", evt_vld, 0);

    // saturation, overflow, clear priority
    do_reset();
    evt_rdy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tgl_in[0] = ~tgl_in[0];
      tick(2);
    end
    tick(6);
    check("sat_ovf", ovf, 4'b0001);
    check("sat_vld", evt_vld, 1);
    check("sat_ch",  evt_ch, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("sat_clr", ovf, 4'b0000);
    tgl_in[0] = ~tgl_in[0];
    tick(2 + FLT);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("sat_set_wins", ovf, 4'b0001);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("sat_clr2", ovf, 4'b0000);
    evt_rdy = 1'b1;
    tick(14);
    check("sat_drain", q_ch.size(), 8);
    check("sat_ovf_end", ovf, 0);

    // rising-edge mode
    do_reset();
    evt_rdy = 1'b1;
    tgl_r[0] = 1'b1;
    tick(6);
    tgl_r[0] = 1'b0;
    tick(6);
    tgl_r[0] = 1'b1;
    tick(6);
    check("rise_n", n_rise, 2);
    check("rise_main_quiet", q_ch.size(), 0);

    // reset mid-operation discards pending events
    do_reset();
    evt_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tgl_in[2] = ~tgl_in[2];
      tick(2);
    end
    tick(4);
    check("mid_vld_pre", evt_vld, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_vld_post", evt_vld, 0);
    evt_rdy = 1'b1;
    tick(10);
    check("mid_quiet", q_ch.size(), 0);
    check("mid_vld_end", evt_vld, 0);

    // levels held high through reset give one event each
    tgl_in = 4'b0010;
    tgl_r  = 4'b0001;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    q_ch.delete();
    n_rise = 0;
    tick(8);
    check("hold_n",    q_ch.size(), 1);
    check("hold_ch",   qv(0), 1);
    check("hold_rise", n_rise, 1);

    // single-cycle blip on one channel
    do_reset();
    tgl_in[3] = 1'b1;
    tick();
    tgl_in[3] = 1'b0;
    tick(8);
    check("blip_n", q_ch.size(), (FLT == 1) ? 0 : 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
